uart_sram_writer: RTL and testbench
===================================

// Module: uart_sram_writer
// PURPOSE
//  Upstream stage of the SRAM display path. Pairs received UART bytes into 16-bit sample words.
//  Buffers the words in a small FIFO and writes them sequentially into the SRAM sample buffer.
//  SRAM_control and the SRAM read stage later read that buffer for VGA display.
//  SRAM is written only while the display side grants the bus (wr_grant), so reads are never disturbed.
// PARAMETERS
//  BUF_WORDS   640  number of 16-bit words in the circular sample buffer (one screen width)
//  FIFO_DEPTH  4    word FIFO depth, power of two
//  ADDR_W      20   SRAM address width
// PORTS
//  pixel_clk    in   1       single clock for all logic
//  R            in   1       synchronous active-high reset
//  rx_data      in   8       received UART byte
//  rx_valid     in   1       one-cycle strobe: rx_data valid
//  stop         in   1       freeze capture: bytes ignored, no new SRAM writes started
//  wr_grant     in   1       display side releases SRAM bus (blanking window)
//  SRAM_ADDR    out  ADDR_W  write address
//  SRAM_DQ_wr   out  16      write data
//  SRAM_DQ_oe   out  1       1 = drive SRAM_DQ with SRAM_DQ_wr
//  SRAM_WE_N    out  1       write strobe, active low
//  SRAM_OE_N    out  1       1 during the writer's bus ownership, 0 otherwise
//  wr_busy      out  1       writer owns the bus (any state except IDLE)
//  frame_wrap   out  1       one-cycle pulse when the write address wraps to 0
//  overflow     out  1       sticky: a word was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (R=1 at edge): byte_phase=0, FIFO empty, addr=0, state=IDLE.
//   Reset outputs: SRAM_WE_N=1, SRAM_DQ_oe=0, SRAM_OE_N=0, wr_busy=0, frame_wrap=0, overflow=0.
//   A reset during a write aborts it; WE_N is 1 in the cycle after the reset edge.
//  Byte pairing: rx_valid with byte_phase=0 latches the low byte.
//   rx_valid with byte_phase=1 forms {rx_data, low} and pushes it to the FIFO the next cycle.
//   byte_phase toggles on each accepted byte.
//   While stop=1, rx_valid is ignored and byte_phase holds.
//  FIFO full at push: the word is dropped and overflow is set until R.
//   A push and a pop in the same cycle with the FIFO full are both honoured, and the word is not dropped.
//  Write FSM, registered outputs:
//   IDLE: leave when FIFO not empty && wr_grant && !stop, go to SETUP.
//   SETUP: ADDR=addr, DQ_wr=FIFO head, DQ_oe=1, OE_N=1, WE_N=1.
//   STROBE: WE_N=0, address and data stable.
//   RELEASE: WE_N=1, data still driven, pop FIFO. addr = (addr==BUF_WORDS-1) ? 0 : addr+1.
//    frame_wrap=1 on the wrap. Return to IDLE, where DQ_oe=0 and OE_N=0.
//  Timing: one word takes 3 cycles, and back-to-back words need 4 cycles each (IDLE between them).
//  wr_grant or stop falling mid-write: the current write completes; no new write is started.
//   The display side must drop wr_grant ≥3 cycles before it needs the bus.
//  Latency: the second byte strobe reaches WE_N low in ≥3 cycles when granted and the FIFO was empty.
//  Arithmetic: addr is ADDR_W wide, upper bits are always 0 below BUF_WORDS, and the wrap compare is exact.
// STRUCTURE
//  Shared package sram_pkg: BUF_WORDS, ADDR_W, write-FSM state encoding (IDLE/SETUP/STROBE/RELEASE).
//   SRAM_control uses the same BUF_WORDS value for its read wrap.
//  Sub-module word_fifo: synchronous FIFO with FIFO_DEPTH entries of 16 bits.
//   Ports: push, pop, din, dout, full, empty. Same-cycle push+pop is allowed when full.
//  Top level: byte pairer, write FSM, address counter, overflow flag.
// TESTING
//  1. Reset, then bytes 0x34, 0x12 with wr_grant=1.
//     -> WE_N low once, ADDR=0, DQ_wr=0x1234, DQ_oe=1. Afterwards addr=1.
//  2. Ten bytes with wr_grant=0 and FIFO_DEPTH=4.
//     -> four words queued, fifth dropped, overflow=1. Raise grant -> exactly 4 writes to ADDR 0..3.
//  3. Preload addr=BUF_WORDS-1 (write 639 words), then write one more word.
//     -> it goes to ADDR=639, frame_wrap pulses once, and the next write goes to ADDR=0.
//  4. Drop wr_grant in the cycle after SETUP.
//     -> STROBE/RELEASE still complete, and no further write occurs while the FIFO stays non-empty.
//  5. stop=1 while bytes arrive.
//     -> no FIFO push, byte_phase unchanged. stop=0 plus the next two bytes -> one correct word.
//  6. Assert R during STROBE.
//     -> the next cycle has WE_N=1, DQ_oe=0, wr_busy=0, addr=0, overflow=0, FIFO empty.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants for the SRAM sample-buffer path: buffer geometry and writer FSM encoding.
// SRAM_control uses the same BUF_WORDS value for its read-side wrap.
package sram_pkg;

    localparam int BUF_WORDS  = 640;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 20;
    localparam int WORD_W     = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETUP   = 2'd1;
    localparam logic [1:0] ST_STROBE  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam addr_t LAST_ADDR = addr_t'(BUF_WORDS - 1);

    // Circular buffer successor; the compare is exact so bits above BUF_WORDS stay zero.
    function automatic addr_t next_addr(input addr_t a);
        return (a == LAST_ADDR) ? '0 : a + addr_t'(1);
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO between the byte pairer and the SRAM write FSM.
// A push is accepted while full when a pop retires the head in the same cycle.
module word_fifo
    import sram_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != DEPTH_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage has no reset; an entry is only read after it was written,
    // so its power-up value is never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/uart_sram_writer.sv
// Pairs UART bytes into 16-bit samples, queues them, and writes them into the circular
// SRAM sample buffer only while the display side grants the bus.
module uart_sram_writer
    import sram_pkg::*;
(
    input  logic              pixel_clk,
    input  logic              R,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              stop,
    input  logic              wr_grant,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [WORD_W-1:0] SRAM_DQ_wr,
    output logic              SRAM_DQ_oe,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              wr_busy,
    output logic              frame_wrap,
    output logic              overflow
);

    logic        byte_phase_q, byte_phase_d;
    logic [7:0]  low_byte_q, low_byte_d;
    logic        push_q, push_d;
    word_t       push_word_q, push_word_d;
    logic        overflow_q, overflow_d;

    logic [1:0]  state_q, state_d;
    addr_t       addr_q, addr_d;
    addr_t       sram_addr_q, sram_addr_d;
    word_t       dq_wr_q, dq_wr_d;
    logic        dq_oe_q, dq_oe_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        busy_q, busy_d;
    logic        frame_wrap_q, frame_wrap_d;

    logic        fifo_pop, fifo_full, fifo_empty;
    word_t       fifo_dout;

    // The completed word is pushed one cycle after the high byte arrives.
    always_comb begin
        byte_phase_d = byte_phase_q;
        low_byte_d   = low_byte_q;
        push_d       = 1'b0;
        push_word_d  = push_word_q;
        if (rx_valid && !stop) begin
            if (!byte_phase_q) begin
                low_byte_d   = rx_data;
                byte_phase_d = 1'b1;
            end else begin
                push_d       = 1'b1;
                push_word_d  = {rx_data, low_byte_q};
                byte_phase_d = 1'b0;
            end
        end
    end

    word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (pixel_clk),
        .rst   (R),
        .push  (push_q),
        .pop   (fifo_pop),
        .din   (push_word_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A push into a full FIFO survives only when the writer pops in the same cycle.
    assign overflow_d = overflow_q | (push_q && fifo_full && !fifo_pop);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sram_addr_d  = sram_addr_q;
        dq_wr_d      = dq_wr_q;
        dq_oe_d      = dq_oe_q;
        oe_n_d       = oe_n_q;
        busy_d       = busy_q;
        we_n_d       = 1'b1;
        frame_wrap_d = 1'b0;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && wr_grant && !stop) begin
                    state_d     = ST_SETUP;
                    sram_addr_d = addr_q;
                    dq_wr_d     = fifo_dout;
                    dq_oe_d     = 1'b1;
                    oe_n_d      = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                we_n_d  = 1'b0;
            end
            ST_STROBE: begin
                // Once started, a write always finishes even if the grant is withdrawn.
                state_d      = ST_RELEASE;
                frame_wrap_d = (addr_q == LAST_ADDR);
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                fifo_pop = 1'b1;
                addr_d   = next_addr(addr_q);
                dq_oe_d  = 1'b0;
                oe_n_d   = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                dq_oe_d = 1'b0;
                oe_n_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (R) begin
            byte_phase_q <= 1'b0;
            low_byte_q   <= '0;
            push_q       <= 1'b0;
            push_word_q  <= '0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            sram_addr_q  <= '0;
            dq_wr_q      <= '0;
            dq_oe_q      <= 1'b0;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_wrap_q <= 1'b0;
        end else begin
            byte_phase_q <= byte_phase_d;
            low_byte_q   <= low_byte_d;
            push_q       <= push_d;
            push_word_q  <= push_word_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            addr_q       <= addr_d;
            sram_addr_q  <= sram_addr_d;
            dq_wr_q      <= dq_wr_d;
            dq_oe_q      <= dq_oe_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            busy_q       <= busy_d;
            frame_wrap_q <= frame_wrap_d;
        end
    end

    assign SRAM_ADDR  = sram_addr_q;
    assign SRAM_DQ_wr = dq_wr_q;
    assign SRAM_DQ_oe = dq_oe_q;
    assign SRAM_WE_N  = we_n_q;
    assign SRAM_OE_N  = oe_n_q;
    assign wr_busy    = busy_q;
    assign frame_wrap = frame_wrap_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_sram_writer.sv
// Self-checking bench for uart_sram_writer: scoreboard of expected SRAM writes,
// a table of word vectors, and hand-written sequences for the multi-cycle corner cases.
module tb_uart_sram_writer;
    import sram_pkg::*;

    logic              pixel_clk = 1'b0;
    logic              R         = 1'b1;
    logic [7:0]        rx_data   = '0;
    logic              rx_valid  = 1'b0;
    logic              stop      = 1'b0;
    logic              wr_grant  = 1'b0;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [WORD_W-1:0] SRAM_DQ_wr;
    logic              SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N, wr_busy, frame_wrap, overflow;

    always #5 pixel_clk = ~pixel_clk;

    uart_sram_writer dut (
        .pixel_clk  (pixel_clk),
        .R          (R),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .stop       (stop),
        .wr_grant   (wr_grant),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_wr (SRAM_DQ_wr),
        .SRAM_DQ_oe (SRAM_DQ_oe),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .wr_busy    (wr_busy),
        .frame_wrap (frame_wrap),
        .overflow   (overflow)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    typedef struct {
        logic [7:0]        lo;
        logic [7:0]        hi;
        logic [ADDR_W-1:0] exp_addr;
        logic [15:0]       exp_data;
    } vec_t;

    wr_t               sb[$];
    logic [ADDR_W-1:0] exp_addr    = '0;
    int                errors      = 0;
    int                checks      = 0;
    int                write_count = 0;
    int                wrap_count  = 0;
    int                strobe_len  = 0;
    logic              we_n_prev   = 1'b1;
    logic              fw_prev     = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Write monitor: every falling WE_N must match the head of the scoreboard.
    always @(negedge pixel_clk) begin
        wr_t e;
        if (!SRAM_WE_N && we_n_prev) begin
            write_count++;
            strobe_len = 1;
            check("write_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("write_addr", 32'(SRAM_ADDR), 32'(e.addr));
                check("write_data", 32'(SRAM_DQ_wr), 32'(e.data));
                check("write_dq_oe", 32'(SRAM_DQ_oe), 32'd1);
                check("write_oe_n", 32'(SRAM_OE_N), 32'd1);
            end
        end else if (!SRAM_WE_N) begin
            strobe_len++;
        end else if (!we_n_prev) begin
            check("strobe_len", 32'(strobe_len), 32'd1);
        end
        if (frame_wrap) begin
            wrap_count++;
            check("wrap_addr", 32'(SRAM_ADDR), 32'(BUF_WORDS - 1));
            check("wrap_single", 32'(fw_prev), 32'd0);
        end
        we_n_prev = SRAM_WE_N;
        fw_prev   = frame_wrap;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        tick(2);
    endtask

    task automatic exp_push(input logic [15:0] data);
        sb.push_back({exp_addr, data});
        exp_addr = (exp_addr == ADDR_W'(BUF_WORDS - 1)) ? '0 : exp_addr + 1'b1;
    endtask

    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi, input bit expect_write);
        if (expect_write) exp_push({hi, lo});
        send_byte(lo);
        send_byte(hi);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || wr_busy) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, (sb.size() == 0 && !wr_busy) ? 32'd1 : 32'd0, 32'd1);
        tick(2);
    endtask

    task automatic do_reset();
        R = 1'b1;
        tick(2);
        R        = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        vec_t vecs[5];
        int   base;
        int   lat;
        int   n;
        logic [15:0] w;

        vecs[0] = '{8'h00, 8'h00, 20'd1, 16'h0000};
        vecs[1] = '{8'hFF, 8'hFF, 20'd2, 16'hFFFF};
        vecs[2] = '{8'h5A, 8'hA5, 20'd3, 16'hA55A};
        vecs[3] = '{8'hFF, 8'h00, 20'd4, 16'h00FF};
        vecs[4] = '{8'h01, 8'h80, 20'd5, 16'h8001};

        // 1. Reset state, first word, latency, then a table of words
        do_reset();
        check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check("rst_dq_oe", 32'(SRAM_DQ_oe), 32'd0);
        check("rst_oe_n", 32'(SRAM_OE_N), 32'd0);
        check("rst_busy", 32'(wr_busy), 32'd0);
        check("rst_frame_wrap", 32'(frame_wrap), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        wr_grant = 1'b1;
        exp_push(16'h1234);
        send_byte(8'h34);
        rx_data  = 8'h12;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        lat = 0;
        while (SRAM_WE_N && lat < 10) begin
            tick(1);
            lat++;
        end
        check("latency_strobe_seen", 32'(!SRAM_WE_N), 32'd1);
        check("latency_min3", (lat >= 3) ? 32'd1 : 32'd0, 32'd1);
        wait_drain("drain_t1", 50);
        for (int i = 0; i < 5; i++) begin
            sb.push_back({vecs[i].exp_addr, vecs[i].exp_data});
            send_word(vecs[i].lo, vecs[i].hi, 1'b0);
        end
        wait_drain("drain_table", 100);
        check("table_write_count", 32'(write_count), 32'd6);

        // 2a. Full FIFO with push and pop in the same cycle: nothing dropped
        do_reset();
        wr_grant = 1'b0;
        base = write_count;
        for (int i = 0; i < 4; i++) send_word(8'(i), 8'hC0, 1'b1);
        exp_push(16'hC5C4);
        send_byte(8'hC4);
        wr_grant = 1'b1;
        n = 0;
        while (!wr_busy && n < 20) begin
            tick(1);
            n++;
        end
        check("pp_busy_seen", 32'(wr_busy), 32'd1);
        tick(1);
        rx_data  = 8'hC5;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        wait_drain("drain_pushpop", 100);
        check("pp_no_overflow", 32'(overflow), 32'd0);
        check("pp_write_count", 32'(write_count - base), 32'd5);

        // 2b. Ten bytes without grant: four queued, fifth dropped
        do_reset();
        wr_grant = 1'b0;
        base = write_count;
        for (int i = 0; i < 5; i++) send_word(8'(8'h10 + i), 8'h20, (i < 4));
        tick(5);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_no_write_yet", 32'(write_count - base), 32'd0);
        wr_grant = 1'b1;
        wait_drain("drain_ovf", 100);
        tick(20);
        check("ovf_write_count", 32'(write_count - base), 32'd4);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // 3. Wrap at the end of the buffer
        do_reset();
        wr_grant = 1'b1;
        base = wrap_count;
        for (int i = 0; i < BUF_WORDS - 1; i++) begin
            w = 16'(i);
            send_word(w[7:0], w[15:8], 1'b1);
        end
        wait_drain("drain_preload", 100);
        check("no_wrap_before_last", 32'(wrap_count - base), 32'd0);
        send_word(8'hEF, 8'hBE, 1'b1);
        wait_drain("drain_last", 100);
        check("wrap_once", 32'(wrap_count - base), 32'd1);
        send_word(8'h0D, 8'hF0, 1'b1);
        wait_drain("drain_after_wrap", 100);
        check("wrap_still_once", 32'(wrap_count - base), 32'd1);

        // 4. Grant dropped in the cycle after SETUP
        do_reset();
        wr_grant = 1'b0;
        for (int i = 0; i < 5; i++) send_word(8'(8'h40 + i), 8'h4A, (i == 0));
        tick(3);
        check("t4_overflow", 32'(overflow), 32'd1);
        base = write_count;
        wr_grant = 1'b1;
        n = 0;
        while (!wr_busy && n < 20) begin
            tick(1);
            n++;
        end
        check("t4_busy_seen", 32'(wr_busy), 32'd1);
        tick(1);
        wr_grant = 1'b0;
        tick(30);
        check("t4_single_write", 32'(write_count - base), 32'd1);
        check("t4_idle", 32'(wr_busy), 32'd0);

        // 6. Reset during STROBE (three words still queued from above)
        exp_push(16'h4A41);
        wr_grant = 1'b1;
        n = 0;
        while (SRAM_WE_N && n < 20) begin
            tick(1);
            n++;
        end
        check("t6_strobe_seen", 32'(SRAM_WE_N), 32'd0);
        R = 1'b1;
        tick(1);
        check("t6_we_n", 32'(SRAM_WE_N), 32'd1);
        check("t6_dq_oe", 32'(SRAM_DQ_oe), 32'd0);
        check("t6_busy", 32'(wr_busy), 32'd0);
        check("t6_oe_n", 32'(SRAM_OE_N), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        R        = 1'b0;
        exp_addr = '0;
        base     = write_count;
        tick(20);
        check("t6_fifo_empty", 32'(write_count - base), 32'd0);
        send_word(8'h99, 8'h77, 1'b1);
        wait_drain("drain_t6", 100);

        // 5. stop freezes byte capture and new writes
        do_reset();
        wr_grant = 1'b1;
        base = write_count;
        stop = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        stop = 1'b0;
        tick(10);
        check("t5_no_push", 32'(write_count - base), 32'd0);
        send_word(8'h78, 8'h56, 1'b1);
        wait_drain("drain_t5a", 100);
        exp_push(16'hBBAA);
        send_byte(8'hAA);
        stop = 1'b1;
        send_byte(8'h11);
        stop = 1'b0;
        send_byte(8'hBB);
        wait_drain("drain_t5b", 100);
        wr_grant = 1'b0;
        base = write_count;
        send_word(8'hFE, 8'hCA, 1'b1);
        stop     = 1'b1;
        wr_grant = 1'b1;
        tick(20);
        check("t5_stop_blocks_write", 32'(write_count - base), 32'd0);
        stop = 1'b0;
        wait_drain("drain_t5c", 100);
        check("t5_write_after_stop", 32'(write_count - base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
